rptr_empty_fwft: RTL

- Read-side pointer, empty-flag and show-ahead output stage of the async FIFO, in the rclk domain.
- Mirrors the write-side pointer/full block: consumes the synchronized gray write pointer `rq2_wptr` and drives the binary memory read address `raddr`.
- Publishes the gray read pointer `rptr` to the read-to-write synchronizer.
- Presents data through a registered valid/ready output, first-word-fall-through. Also reports fill level and almost-empty.

---
 rtl/rptr_empty_fwft.sv | 119 +++++++++++
 1 files changed

// File: rtl/rptr_empty_fwft.sv
// rtl/rptr_empty_fwft.sv - async FIFO read pointer, empty flag and FWFT output register
// Optional macro RPTR_CHECK_EN enables the sticky pointer-consistency error rerr.
module rptr_empty_fwft #(
  parameter int ASIZE     = 4,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             rvalid,
  input  logic             rready,
  output logic [DSIZE-1:0] rdata,
  output logic [ASIZE:0]   rlevel,
  output logic             ralmost_empty,
  output logic             rerr
);

  localparam logic [ASIZE:0] AE_LIM    = AE_THRESH[ASIZE:0];
  localparam logic [ASIZE:0] DEPTH_LIM = {1'b1, {ASIZE{1'b0}}};

  logic [ASIZE:0]   rbin_q, rbin_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic             rvalid_q, rvalid_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [ASIZE:0]   rlevel_q, rlevel_d;
  logic             rae_q, rae_d;
  logic [ASIZE:0]   wbin;
  logic             rinc;

  // Gray-to-binary of the synchronized write pointer: XOR prefix from the MSB.
  always_comb begin
    wbin = '0;
    wbin[ASIZE] = rq2_wptr[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
  end

  always_comb begin
    rinc     = !rempty_q && (!rvalid_q || rready);
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, rinc};
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = wbin - rbin_d;
    rae_d    = (rlevel_d <= AE_LIM);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rinc) begin
      rvalid_d = 1'b1;
      rdata_d  = rdata_mem;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlevel_q <= '0;
      rae_q    <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlevel_q <= rlevel_d;
      rae_q    <= rae_d;
    end
  end

  assign raddr         = rbin_q[ASIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rlevel        = rlevel_q;
  assign ralmost_empty = rae_q;

`ifdef RPTR_CHECK_EN
  logic             hold_q;
  logic [DSIZE-1:0] held_q;
  logic             rerr_q, rerr_d;

  // held_q captures the word that was being held back, compared one edge later.
  always_comb begin
    rerr_d = rerr_q;
    if (rlevel_d > DEPTH_LIM) rerr_d = 1'b1;
    if (hold_q && (held_q != rdata_q)) rerr_d = 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      hold_q <= 1'b0;
      held_q <= '0;
      rerr_q <= 1'b0;
    end else begin
      hold_q <= rvalid_q && !rready;
      held_q <= rdata_q;
      rerr_q <= rerr_d;
    end
  end

  assign rerr = rerr_q;
`else
  assign rerr = 1'b0;
`endif

endmodule
